// File: rtl/tensor_mm_pkg.sv
// Shared types, default sizes and helpers for the tensor matrix-multiply engine.
// Latency: none (package only).
// Backpressure: not applicable.
package tensor_mm_pkg;

  localparam int DATAWIDTH_DEF = 8;
  localparam int ACCWIDTH_DEF  = 24;
  localparam int ROWS_DEF      = 4;
  localparam int COLS_DEF      = 4;
  localparam int KMAX_DEF      = 8;

  // LOAD_BIAS is only ever entered when the bias path is compiled in.
  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    LOAD_BIAS,
    COMPUTE,
    OUTPUT
  } state_t;

  // Clamp a 64-bit signed value into the range of a w-bit signed number.
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/tensor_mm_stream_if.sv
// Operand-in / result-out valid-ready streams of the matrix-multiply engine.
// Latency: none (wiring only).
// Backpressure: in_ready throttles the source, out_ready throttles the engine.
interface tensor_mm_stream_if #(
  parameter int DATAWIDTH = 8,
  parameter int ACCWIDTH  = 24
);
  logic                        in_valid;
  logic                        in_ready;
  logic signed [DATAWIDTH-1:0] in_data;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [ACCWIDTH-1:0]  out_data;
  logic                        out_last;

  // Host / DMA side.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  // Engine side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/tensor_mm_pe.sv
// One output-stationary PE: saturating signed MAC, operands forwarded east/south.
// Latency: one cycle for both the accumulate and the a/b pass-through.
// Backpressure: none; only advances while en_i is high.
module tensor_mm_pe #(
  parameter int DATAWIDTH = 8,
  parameter int ACCWIDTH  = 24
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clr_i,
  input  logic                        en_i,
  input  logic signed [DATAWIDTH-1:0] a_i,
  input  logic signed [DATAWIDTH-1:0] b_i,
  output logic signed [DATAWIDTH-1:0] a_o,
  output logic signed [DATAWIDTH-1:0] b_o,
  output logic signed [ACCWIDTH-1:0]  acc_o
);
  import tensor_mm_pkg::*;

  logic signed [DATAWIDTH-1:0]   a_q, b_q;
  logic signed [ACCWIDTH-1:0]    acc_q, acc_d;
  logic signed [2*DATAWIDTH-1:0] prod;
  logic signed [63:0]            sum;

  // Full-precision product, then a 64-bit sum that is clamped back into the accumulator.
  always_comb begin
    prod  = $signed({{DATAWIDTH{a_i[DATAWIDTH-1]}}, a_i}) * $signed({{DATAWIDTH{b_i[DATAWIDTH-1]}}, b_i});
    sum   = $signed({{(64-ACCWIDTH){acc_q[ACCWIDTH-1]}}, acc_q})
          + $signed({{(64-2*DATAWIDTH){prod[2*DATAWIDTH-1]}}, prod});
    acc_d = ACCWIDTH'(sat(sum, ACCWIDTH));
  end

  // Clear also flushes the skew registers so a new job starts from an empty grid.
  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else if (en_i) begin
      a_q   <= a_i;
      b_q   <= b_i;
      acc_q <= acc_d;
    end
  end

  assign a_o   = a_q;
  assign b_o   = b_q;
  assign acc_o = acc_q;
endmodule

// File: rtl/tensor_mm_stream.sv
// X = A*B (+bias when TENSOR_MM_BIAS_EN is defined, optional ReLU) on a ROWS x COLS systolic grid.
// Latency: K+ROWS+COLS-1 cycles from the last operand word to the first result word.
// Backpressure: in_ready only in load states; out_valid/out_data/out_last hold until out_ready.
module tensor_mm_stream
  import tensor_mm_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEF,
  parameter int ACCWIDTH  = ACCWIDTH_DEF,
  parameter int ROWS      = ROWS_DEF,
  parameter int COLS      = COLS_DEF,
  parameter int KMAX      = KMAX_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [$clog2(ROWS):0]      cfg_m,
  input  logic [$clog2(COLS):0]      cfg_n,
  input  logic [$clog2(KMAX):0]      cfg_k,
  input  logic                       cfg_relu,
  tensor_mm_stream_if.slave          bus,
  output logic                       busy,
  output logic                       done,
  output logic                       cfg_err
);
  localparam int MW   = $clog2(ROWS) + 1;
  localparam int NW   = $clog2(COLS) + 1;
  localparam int KW   = $clog2(KMAX) + 1;
  localparam int RIW  = $clog2(ROWS);
  localparam int CIW  = $clog2(COLS);
  localparam int KIW  = $clog2(KMAX);
  localparam int DM1  = (KMAX > ROWS) ? KMAX : ROWS;
  localparam int DM2  = (DM1 > COLS) ? DM1 : COLS;
  localparam int IW   = $clog2(DM2 + 1);
  localparam int CNTW = $clog2(KMAX + ROWS + COLS);
  localparam logic [MW-1:0] M_MAX = MW'(ROWS);
  localparam logic [NW-1:0] N_MAX = NW'(COLS);
  localparam logic [KW-1:0] K_MAX = KW'(KMAX);

  state_t                      state_q, state_d;
  logic [MW-1:0]               m_q;
  logic [NW-1:0]               n_q;
  logic [KW-1:0]               k_q;
  logic                        relu_q;
  logic [IW-1:0]               i_q, j_q, row_last, col_last;
  logic [CNTW-1:0]             cnt_q, cnt_last;
  logic                        done_q, done_d, cfg_err_q, cfg_err_d;
  logic                        clr, comp, xfer, pop, elem_last, cfg_ok;
  logic signed [ACCWIDTH-1:0]  res;

  logic signed [DATAWIDTH-1:0] a_buf [ROWS][KMAX];
  logic signed [DATAWIDTH-1:0] b_buf [KMAX][COLS];
`ifdef TENSOR_MM_BIAS_EN
  logic signed [DATAWIDTH-1:0] bias_buf [ROWS][COLS];
`endif

  logic signed [DATAWIDTH-1:0] fa [ROWS];
  logic signed [DATAWIDTH-1:0] fb [COLS];
  logic signed [DATAWIDTH-1:0] ah [ROWS][COLS];
  logic signed [DATAWIDTH-1:0] bh [ROWS][COLS];
  logic signed [ACCWIDTH-1:0]  acc [ROWS][COLS];

  assign comp   = (state_q == COMPUTE);
  assign xfer   = bus.in_valid && bus.in_ready;
  assign pop    = bus.out_valid && bus.out_ready;
  assign cfg_ok = (cfg_m != '0) && (cfg_m <= M_MAX) && (cfg_n != '0) && (cfg_n <= N_MAX)
               && (cfg_k != '0) && (cfg_k <= K_MAX);
  assign cnt_last = CNTW'(k_q) + CNTW'(ROWS + COLS - 3);

  // Row/column bounds of whichever matrix is currently being streamed in or out.
  always_comb begin
    row_last = '0;
    col_last = '0;
    case (state_q)
      LOAD_A: begin
        row_last = IW'(m_q) - IW'(1);
        col_last = IW'(k_q) - IW'(1);
      end
      LOAD_B: begin
        row_last = IW'(k_q) - IW'(1);
        col_last = IW'(n_q) - IW'(1);
      end
      LOAD_BIAS, OUTPUT: begin
        row_last = IW'(m_q) - IW'(1);
        col_last = IW'(n_q) - IW'(1);
      end
      default: ;
    endcase
    elem_last = (i_q == row_last) && (j_q == col_last);
  end

  // Job sequencing: next state, accumulator clear, done and config-error pulses.
  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    cfg_err_d = 1'b0;
    clr       = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        if (cfg_ok) begin
          state_d = LOAD_A;
          clr     = 1'b1;
        end else begin
          cfg_err_d = 1'b1;
        end
      end
      LOAD_A: if (xfer && elem_last) state_d = LOAD_B;
`ifdef TENSOR_MM_BIAS_EN
      LOAD_B:    if (xfer && elem_last) state_d = LOAD_BIAS;
      LOAD_BIAS: if (xfer && elem_last) state_d = COMPUTE;
`else
      LOAD_B:    if (xfer && elem_last) state_d = COMPUTE;
`endif
      COMPUTE: if (cnt_q == cnt_last) state_d = OUTPUT;
      OUTPUT: if (pop && elem_last) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers: state, latched config, element indices and the compute cycle counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      m_q       <= '0;
      n_q       <= '0;
      k_q       <= '0;
      relu_q    <= 1'b0;
      i_q       <= '0;
      j_q       <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
      cnt_q     <= comp ? cnt_q + CNTW'(1) : '0;
      if (clr) begin
        m_q    <= cfg_m;
        n_q    <= cfg_n;
        k_q    <= cfg_k;
        relu_q <= cfg_relu;
        i_q    <= '0;
        j_q    <= '0;
      end else if (xfer || pop) begin
        if (j_q == col_last) begin
          j_q <= '0;
          i_q <= (i_q == row_last) ? '0 : i_q + IW'(1);
        end else begin
          j_q <= j_q + IW'(1);
        end
      end
    end
  end

  // Operand storage; stale entries beyond the current M/N/K are masked at the feed.
  always_ff @(posedge clk) begin
    if (xfer) begin
      case (state_q)
        LOAD_A: a_buf[RIW'(i_q)][KIW'(j_q)] <= bus.in_data;
        LOAD_B: b_buf[KIW'(i_q)][CIW'(j_q)] <= bus.in_data;
`ifdef TENSOR_MM_BIAS_EN
        LOAD_BIAS: bias_buf[RIW'(i_q)][CIW'(j_q)] <= bus.in_data;
`endif
        default: ;
      endcase
    end
  end

  // Skewed edge feeds: row r sees A[r][t-r], column c sees B[t-c][c]. When t<r the
  // subtraction wraps past KMAX, so the single k-bound also rejects it.
  for (genvar r = 0; r < ROWS; r++) begin : g_fa
    logic [CNTW-1:0] kk;
    assign kk    = cnt_q - CNTW'(r);
    assign fa[r] = (comp && (kk < CNTW'(k_q)) && (MW'(r) < m_q)) ? a_buf[r][KIW'(kk)] : '0;
  end
  for (genvar c = 0; c < COLS; c++) begin : g_fb
    logic [CNTW-1:0] kk;
    assign kk    = cnt_q - CNTW'(c);
    assign fb[c] = (comp && (kk < CNTW'(k_q)) && (NW'(c) < n_q)) ? b_buf[KIW'(kk)][c] : '0;
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic signed [DATAWIDTH-1:0] a_in, b_in;
      if (c == 0) begin : g_aw
        assign a_in = fa[r];
      end else begin : g_an
        assign a_in = ah[r][c-1];
      end
      if (r == 0) begin : g_bn
        assign b_in = fb[c];
      end else begin : g_bs
        assign b_in = bh[r-1][c];
      end
      tensor_mm_pe #(.DATAWIDTH(DATAWIDTH), .ACCWIDTH(ACCWIDTH)) u_pe (
        .clk   (clk),
        .reset (reset),
        .clr_i (clr),
        .en_i  (comp),
        .a_i   (a_in),
        .b_i   (b_in),
        .a_o   (ah[r][c]),
        .b_o   (bh[r][c]),
        .acc_o (acc[r][c])
      );
    end
  end

  // Result path for the word at (i,j): bias add, clamp, then ReLU.
  always_comb begin
    logic signed [ACCWIDTH-1:0] a_sel;
    logic signed [63:0]         wide;
    a_sel = acc[RIW'(i_q)][CIW'(j_q)];
    wide  = $signed({{(64-ACCWIDTH){a_sel[ACCWIDTH-1]}}, a_sel});
`ifdef TENSOR_MM_BIAS_EN
    wide  = wide + $signed({{(64-DATAWIDTH){bias_buf[RIW'(i_q)][CIW'(j_q)][DATAWIDTH-1]}},
                            bias_buf[RIW'(i_q)][CIW'(j_q)]});
`endif
    res = ACCWIDTH'(sat(wide, ACCWIDTH));
    if (relu_q && res[ACCWIDTH-1]) res = '0;
  end

  assign bus.in_ready  = (state_q == LOAD_A) || (state_q == LOAD_B) || (state_q == LOAD_BIAS);
  assign bus.out_valid = (state_q == OUTPUT);
  assign bus.out_data  = bus.out_valid ? res : '0;
  assign bus.out_last  = bus.out_valid && elem_last;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign cfg_err       = cfg_err_q;
endmodule
